stepper_cmd_sequencer: RTL and testbench

//  Upstream feeder for the stepper driver. Buffers 23-bit motion commands from the processor
//  ({mode[22:21], target_pos[20:0]}) in a FIFO and issues them to the driver one at a time.

---
 rtl/stepper_cmd_sequencer.sv | 135 +++++++++++++
 tb/tb_stepper_cmd_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_cmd_sequencer.sv
// Command FIFO and issue sequencer for the stepper driver: queues 23-bit motion commands
// and hands them to the driver one at a time, waiting for each move to finish.
//
// state  | meaning
// IDLE   | waiting for a queued command and an idle driver
// ISSUE  | new_data pulse cycle, command on data_out
// SETTLE | driver latch/compare latency, stepper_busy ignored
// WAIT   | waiting for the driver to finish the move
module stepper_cmd_sequencer #(
  parameter int DEPTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                         CLK100MHZ,
  input  logic                         CPU_RESETN,
  input  logic                         wr_en,
  input  logic [31:0]                  wr_data,
  input  logic                         flush,
  input  logic                         clear_ovf,
  input  logic                         stepper_busy,
  output logic [31:0]                  data_out,
  output logic                         new_data,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         idle,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [22:0]   mem_q [DEPTH];
  logic [22:0]   mem_d [DEPTH];
  logic [31:0]   data_out_q, data_out_d;
  logic          new_data_q, new_data_d;
  logic          overflow_q, overflow_d;
  logic          pop, push, drop;
  logic          unused_wr_bits;

  assign unused_wr_bits = ^wr_data[31:23];

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    data_out_d = data_out_q;
    new_data_d = 1'b0;

    // flush cancels any pop, so the FSM cannot leave IDLE in a flush cycle
    pop  = (state_q == S_IDLE) && (count_q != '0) && !stepper_busy && !flush;
    push = wr_en && !flush && ((count_q != CW'(DEPTH)) || pop);
    drop = wr_en && !flush && !push;

    overflow_d = drop | (overflow_q & ~clear_ovf);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          data_out_d = {9'b0, mem_q[rd_ptr_q]};
          new_data_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = S_WAIT;
        else                                    settle_d = settle_q + SW'(1);
      end
      default: begin
        if (!stepper_busy) state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data[22:0];
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q    <= S_IDLE;
      settle_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      new_data_q <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      new_data_q <= new_data_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign data_out = data_out_q;
  assign new_data = new_data_q;
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign overflow = overflow_q;
  assign idle     = (state_q == S_IDLE) && (count_q == '0) && !stepper_busy;

endmodule

// File: tb/tb_stepper_cmd_sequencer.sv
// Scoreboard bench for stepper_cmd_sequencer: accepted writes queue expected commands,
// each new_data pulse pops and compares; a simple driver model generates stepper_busy.
module tb_stepper_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int SC    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        flush = 1'b0;
  logic        clear_ovf = 1'b0;
  logic        busy_m = 1'b0;
  logic        busy_f = 1'b0;
  logic        stepper_busy;
  logic [31:0] data_out;
  logic        new_data, full, idle, overflow;
  logic [3:0]  count;

  assign stepper_busy = busy_m | busy_f;

  stepper_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SC)) dut (
    .CLK100MHZ    (clk),
    .CPU_RESETN   (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .clear_ovf    (clear_ovf),
    .stepper_busy (stepper_busy),
    .data_out     (data_out),
    .new_data     (new_data),
    .full         (full),
    .count        (count),
    .idle         (idle),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_pulses = 0;
  int          last_pulse = 0;
  int          fall_cyc = 0;
  int          hold = 0;
  int          busy_left = 0;
  bit          have_pulse = 0;
  bit          fall_valid = 0;
  bit          prev_nd = 0;
  bit          prev_busy = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input bit acc);
    wr_en   = 1'b1;
    wr_data = d;
    if (acc) exp_q.push_back({9'b0, d[22:0]});
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    bit done;
    done = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (idle && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    chk(tag, 32'(done), 32'd1);
    tick();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // driver model: busy for 'hold' cycles after each issue
  initial forever begin
    @(posedge clk);
    #1;
    if (new_data && hold > 0) busy_left = hold;
    else if (busy_left > 0)   busy_left--;
    busy_m = (busy_left > 0);
  end

  initial forever begin
    @(negedge clk);
    if (new_data) begin
      chk("nd_width", 32'(prev_nd), 32'd0);
      chk("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("issue_data", data_out, exp_q.pop_front());
      if (have_pulse) chk("spacing", 32'((cyc - last_pulse) >= SC + 2), 32'd1);
      if (fall_valid) chk("after_busy_fall", 32'((cyc - fall_cyc) >= 1), 32'd1);
      n_pulses++;
      last_pulse = cyc;
      have_pulse = 1;
      fall_valid = 0;
    end
    if (prev_busy && !stepper_busy) begin
      fall_cyc   = cyc;
      fall_valid = 1;
    end
    prev_nd   = new_data;
    prev_busy = stepper_busy;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int idle_cyc;
    bit found;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_nd", 32'(new_data), 32'd0);
    chk("rst_dout", data_out, 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;
    tick();

    // single command, driver idle
    hold = 0;
    wr(32'h0000_0064, 1);
    @(negedge clk);
    chk("lat_nd_early", 32'(new_data), 32'd0);
    @(negedge clk);
    chk("lat_nd", 32'(new_data), 32'd1);
    chk("lat_dout", data_out, 32'h0000_0064);
    chk("lat_count", 32'(count), 32'd0);
    tick();
    wait_idle("t1_done", 40);
    chk("t1_pulses", 32'(n_pulses), 32'd1);

    // three commands with long moves
    hold = 50;
    wr(32'h0000_0010, 1);
    wr(32'h0000_0020, 1);
    wr(32'h0020_0000, 1);
    chk("t2_count", 32'(count), 32'd2);
    wait_idle("t2_done", 400);
    chk("t2_pulses", 32'(n_pulses), 32'd4);

    // overfill while driver busy; upper bits must be stripped
    hold = 0;
    for (int i = 0; i < 10; i++) begin
      wr(32'hFF80_0000 | 32'(i * 3 + 1), i < 9);
      if (i == 1) busy_f = 1'b1;
    end
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 32'd0);

    // write in the same cycle as the pop from a full FIFO
    busy_f = 1'b0;
    tick();
    wr(32'h0000_0ABC, 1);
    busy_f = 1'b1;
    chk("t4_nd", 32'(new_data), 32'd1);
    chk("t4_count", 32'(count), 32'd8);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd0);

    // flush during WAIT, with and without same-cycle write
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    chk("t5_flush1", 32'(count), 32'd0);
    wr(32'h0000_0101, 1);
    wr(32'h0000_0102, 1);
    wr(32'h0000_0103, 1);
    chk("t5_count3", 32'(count), 32'd3);
    flush   = 1'b1;
    wr(32'h0000_0104, 0);
    flush   = 1'b0;
    exp_q.delete();
    chk("t5_count0", 32'(count), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    p0 = n_pulses;
    busy_f = 1'b0;
    repeat (30) tick();
    chk("t5_no_issue", 32'(n_pulses), 32'(p0));
    chk("t5_idle", 32'(idle), 32'd1);

    // reset during SETTLE with two queued
    wr(32'h0000_0201, 1);
    wr(32'h0000_0202, 1);
    wr(32'h0000_0203, 1);
    tick();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_nd", 32'(new_data), 32'd0);
    chk("t6_dout", data_out, 32'd0);
    chk("t6_idle", 32'(idle), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("t6_post_count", 32'(count), 32'd0);

    // mode-11 command: busy never rises
    p0 = n_pulses;
    found = 0;
    idle_cyc = 0;
    wr(32'h0060_0000, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (n_pulses == p0 + 1 && idle) begin
        found = 1;
        idle_cyc = cyc;
        break;
      end
    end
    chk("m11_found", 32'(found), 32'd1);
    chk("m11_idle_lat", 32'(idle_cyc - last_pulse), 32'(SC + 2));
    repeat (10) tick();
    chk("m11_single", 32'(n_pulses), 32'(p0 + 1));
    chk("m11_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
